// File: rtl/dircc_rts_scheduler.sv
// dircc_rts_scheduler
//
// Round-robin send scheduler for a node hosting several devices. Each device
// exposes 32 ready-to-send port flags; the scheduler picks one device/port per
// grant, holds the request to the shared packet send unit until it is
// acknowledged, then pulses a one-hot done strobe back to the served device.
// The served device is masked for COOLDOWN cycles afterwards so its registered
// ready flags have time to reflect the decremented pending-send count.
//
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       allows new grants; an in-flight send always completes
//   rts_ready    device i flags at [32i+31:32i], bit p = port p pending
//   send_valid   request to the send unit
//   send_device  granted device index (stable while send_valid)
//   send_port    one-hot granted port (stable while send_valid)
//   send_ack     same-cycle accept from the send unit
//   send_done    one-cycle one-hot pulse to the served device
//   busy         high while a request is outstanding
//   sent_count   completed transfers, wrapping 32-bit counter

module dircc_rts_scheduler #(
  parameter  int NUM_DEVICES = 4,
  parameter  int COOLDOWN    = 2,
  localparam int DEV_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_DEVICES*32-1:0] rts_ready,
  output logic                      send_valid,
  output logic [DEV_W-1:0]          send_device,
  output logic [31:0]               send_port,
  input  logic                      send_ack,
  output logic [NUM_DEVICES-1:0]    send_done,
  output logic                      busy,
  output logic [31:0]               sent_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [DEV_W-1:0]       LAST_DEV_INIT = DEV_W'(NUM_DEVICES - 1);
  localparam logic [NUM_DEVICES-1:0] DONE_ONE      = NUM_DEVICES'(1);

  state_t                   state_q, state_d;
  logic                     send_valid_q, send_valid_d;
  logic [DEV_W-1:0]         send_device_q, send_device_d;
  logic [31:0]              send_port_q, send_port_d;
  logic [NUM_DEVICES-1:0]   send_done_q, send_done_d;
  logic                     busy_q, busy_d;
  logic [31:0]              sent_count_q, sent_count_d;
  logic [DEV_W-1:0]         last_grant_q, last_grant_d;
  logic [3:0]               cooldown_q, cooldown_d;

  logic [31:0]              dev_flags [NUM_DEVICES];
  logic [NUM_DEVICES-1:0]   eligible;

  logic                     found;
  logic [DEV_W-1:0]         cand_idx;
  logic [DEV_W-1:0]         sel_idx;
  logic [31:0]              sel_flags;
  logic [31:0]              sel_port;

  // Per-device flag slices and eligibility; only the last-served device can
  // be masked, and only while the cooldown counter is running.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_dev
      assign dev_flags[gi] = rts_ready[32*gi +: 32];
      assign eligible[gi]  = (|dev_flags[gi]) &&
                             !((last_grant_q == DEV_W'(gi)) && (cooldown_q != 4'd0));
    end
  endgenerate

  // Round-robin search: first eligible index after last_grant, wrapping.
  // The last candidate examined is last_grant itself, so a lone requester is
  // still served once its cooldown expires.
  always_comb begin
    found    = 1'b0;
    cand_idx = '0;
    sel_idx  = '0;
    for (int k = 1; k <= NUM_DEVICES; k++) begin
      cand_idx = DEV_W'((int'(last_grant_q) + k) % NUM_DEVICES);
      if (!found && eligible[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  // Lowest set port flag of the selected device (x & -x isolates it).
  assign sel_flags = dev_flags[sel_idx];
  assign sel_port  = sel_flags & (~sel_flags + 32'd1);

  always_comb begin
    state_d       = state_q;
    send_valid_d  = send_valid_q;
    send_device_d = send_device_q;
    send_port_d   = send_port_q;
    send_done_d   = '0;
    busy_d        = busy_q;
    sent_count_d  = sent_count_q;
    last_grant_d  = last_grant_q;
    cooldown_d    = (cooldown_q != 4'd0) ? (cooldown_q - 4'd1) : cooldown_q;

    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d       = SEND;
          send_valid_d  = 1'b1;
          send_device_d = sel_idx;
          send_port_d   = sel_port;
          busy_d        = 1'b1;
        end
      end
      SEND: begin
        // Request stays frozen regardless of rts_ready/enable until accepted.
        if (send_ack) begin
          state_d      = IDLE;
          send_valid_d = 1'b0;
          busy_d       = 1'b0;
          send_done_d  = DONE_ONE << send_device_q;
          last_grant_d = send_device_q;
          cooldown_d   = 4'(COOLDOWN);
          sent_count_d = sent_count_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      send_valid_q  <= 1'b0;
      send_device_q <= '0;
      send_port_q   <= '0;
      send_done_q   <= '0;
      busy_q        <= 1'b0;
      sent_count_q  <= '0;
      last_grant_q  <= LAST_DEV_INIT;
      cooldown_q    <= '0;
    end else begin
      state_q       <= state_d;
      send_valid_q  <= send_valid_d;
      send_device_q <= send_device_d;
      send_port_q   <= send_port_d;
      send_done_q   <= send_done_d;
      busy_q        <= busy_d;
      sent_count_q  <= sent_count_d;
      last_grant_q  <= last_grant_d;
      cooldown_q    <= cooldown_d;
    end
  end

  assign send_valid  = send_valid_q;
  assign send_device = send_device_q;
  assign send_port   = send_port_q;
  assign send_done   = send_done_q;
  assign busy        = busy_q;
  assign sent_count  = sent_count_q;

endmodule

// File: tb/tb_dircc_rts_scheduler.sv
// tb_dircc_rts_scheduler
//
// Directed bench for dircc_rts_scheduler (NUM_DEVICES=4, COOLDOWN=2).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_dircc_rts_scheduler;

  localparam int N  = 4;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [N*32-1:0] rts_ready = '0;
  logic          send_valid;
  logic [DW-1:0] send_device;
  logic [31:0]   send_port;
  logic          send_ack = 1'b0;
  logic [N-1:0]  send_done;
  logic          busy;
  logic [31:0]   sent_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dircc_rts_scheduler #(.NUM_DEVICES(N), .COOLDOWN(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .rts_ready   (rts_ready),
    .send_valid  (send_valid),
    .send_device (send_device),
    .send_port   (send_port),
    .send_ack    (send_ack),
    .send_done   (send_done),
    .busy        (busy),
    .sent_count  (sent_count)
  );

  task automatic set_all(input logic [31:0] f0, input logic [31:0] f1,
                         input logic [31:0] f2, input logic [31:0] f3);
    rts_ready = {f3, f2, f1, f0};
  endtask

  // Waits (bounded) for send_valid; cycles = falling edges waited.
  task automatic wait_valid(input int max, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (cycles < max && !ok) begin
      @(negedge clk);
      cycles++;
      if (send_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit seen;
    reset_n = 1'b0; enable = 1'b1; send_ack = 1'b0; set_all(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    compared++; if (send_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %0b want 0", send_valid); end
    compared++; if (send_device !== 2'd0) begin mismatched++; $display("FAIL reset_device got %0d want 0", send_device); end
    compared++; if (send_port !== 32'd0) begin mismatched++; $display("FAIL reset_port got %h want 0", send_port); end
    compared++; if (send_done !== 4'd0) begin mismatched++; $display("FAIL reset_done got %b want 0000", send_done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %0b want 0", busy); end
    compared++; if (sent_count !== 32'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", sent_count); end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (send_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL idle_no_grant got activity=1 want 0"); end
    compared++; if (sent_count !== 32'd0) begin mismatched++; $display("FAIL idle_count got %0d want 0", sent_count); end
    $display("test_reset done");
  endtask

  task automatic test_single;
    bit ok; int cyc;
    set_all(0, 0, 32'h5, 0);
    wait_valid(10, ok, cyc);
    compared++; if (!ok || cyc != 1) begin mismatched++; $display("FAIL single_latency got %0d want 1", cyc); end
    compared++; if (send_device !== 2'd2) begin mismatched++; $display("FAIL single_device got %0d want 2", send_device); end
    compared++; if (send_port !== 32'h1) begin mismatched++; $display("FAIL single_port got %h want 1", send_port); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy got %0b want 1", busy); end
    @(negedge clk);
    compared++; if (send_valid !== 1'b1 || send_device !== 2'd2) begin mismatched++; $display("FAIL single_hold got v=%0b d=%0d want v=1 d=2", send_valid, send_device); end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    compared++; if (send_done !== 4'b0100) begin mismatched++; $display("FAIL single_done got %b want 0100", send_done); end
    compared++; if (send_valid !== 1'b0) begin mismatched++; $display("FAIL single_valid_drop got %0b want 0", send_valid); end
    compared++; if (sent_count !== 32'd1) begin mismatched++; $display("FAIL single_count got %0d want 1", sent_count); end
    @(negedge clk);
    compared++; if (send_done !== 4'b0000 || send_valid !== 1'b0) begin mismatched++; $display("FAIL single_done_once got done=%b v=%0b want 0000/0", send_done, send_valid); end
    // Ack in cycle a; regrant of the same device expected in cycle a+4.
    wait_valid(10, ok, cyc);
    compared++; if (!ok || cyc != 2) begin mismatched++; $display("FAIL cooldown_regrant got %0d want 2", cyc); end
    compared++; if (send_device !== 2'd2 || send_port !== 32'h1) begin mismatched++; $display("FAIL regrant_id got d=%0d p=%h want d=2 p=1", send_device, send_port); end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    set_all(0, 0, 0, 0);
    compared++; if (sent_count !== 32'd2) begin mismatched++; $display("FAIL single_count2 got %0d want 2", sent_count); end
    $display("test_single done");
  endtask

  task automatic test_round_robin;
    bit ok; int cyc;
    int exp_dev [6] = '{0, 1, 2, 3, 0, 1};
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    send_ack = 1'b1;
    set_all(1, 1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      wait_valid(10, ok, cyc);
      compared++;
      if (!ok || cyc != ((i == 0) ? 1 : 2) || send_device !== DW'(exp_dev[i])) begin
        mismatched++;
        $display("FAIL rr_grant%0d got d=%0d after %0d want d=%0d", i, send_device, cyc, exp_dev[i]);
      end
      $display("rr grant %0d device %0d", i, send_device);
      if (i == 5) set_all(0, 0, 0, 0);
    end
    @(negedge clk);
    send_ack = 1'b0;
    compared++; if (send_done !== 4'b0010) begin mismatched++; $display("FAIL rr_last_done got %b want 0010", send_done); end
    compared++; if (sent_count !== 32'd6) begin mismatched++; $display("FAIL rr_count got %0d want 6", sent_count); end
    $display("test_round_robin done");
  endtask

  task automatic test_ack_stall;
    bit ok; int cyc; bit seen;
    set_all(0, 0, 0, 32'h30);
    wait_valid(10, ok, cyc);
    compared++; if (!ok || send_device !== 2'd3 || send_port !== 32'h10) begin mismatched++; $display("FAIL stall_grant got d=%0d p=%h want d=3 p=10", send_device, send_port); end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        enable = 1'b0;
        set_all(32'hFF, 0, 0, 32'h1);
      end
      @(negedge clk);
      compared++;
      if (send_valid !== 1'b1 || send_device !== 2'd3 || send_port !== 32'h10) begin
        mismatched++;
        $display("FAIL stall_hold%0d got v=%0b d=%0d p=%h want 1/3/10", i, send_valid, send_device, send_port);
      end
    end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    compared++; if (send_done !== 4'b1000 || send_valid !== 1'b0) begin mismatched++; $display("FAIL stall_done got done=%b v=%0b want 1000/0", send_done, send_valid); end
    compared++; if (sent_count !== 32'd7) begin mismatched++; $display("FAIL stall_count got %0d want 7", sent_count); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (send_valid !== 1'b0) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL stall_disabled got grant=1 want 0"); end
    enable = 1'b1;
    wait_valid(10, ok, cyc);
    compared++; if (!ok || cyc != 1 || send_device !== 2'd0 || send_port !== 32'h1) begin mismatched++; $display("FAIL stall_reenable got d=%0d p=%h after %0d want d=0 p=1 after 1", send_device, send_port, cyc); end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    set_all(0, 0, 0, 0);
    compared++; if (sent_count !== 32'd8) begin mismatched++; $display("FAIL stall_count2 got %0d want 8", sent_count); end
    $display("test_ack_stall done");
  endtask

  task automatic test_reset_mid_send;
    bit ok; int cyc;
    set_all(0, 32'h8000_0000, 0, 0);
    wait_valid(10, ok, cyc);
    compared++; if (!ok || send_device !== 2'd1 || send_port !== 32'h8000_0000) begin mismatched++; $display("FAIL mid_grant got d=%0d p=%h want d=1 p=80000000", send_device, send_port); end
    set_all(32'h4, 32'h8000_0000, 0, 0);
    send_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    compared++; if (send_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_async got v=%0b busy=%0b want 0/0", send_valid, busy); end
    compared++; if (send_done !== 4'b0000) begin mismatched++; $display("FAIL mid_no_done got %b want 0000", send_done); end
    compared++; if (sent_count !== 32'd0) begin mismatched++; $display("FAIL mid_count got %0d want 0", sent_count); end
    @(negedge clk);
    send_ack = 1'b0;
    compared++; if (send_done !== 4'b0000) begin mismatched++; $display("FAIL mid_no_done2 got %b want 0000", send_done); end
    reset_n = 1'b1;
    // Search restarts at device 0, so device 0 wins over device 1.
    wait_valid(10, ok, cyc);
    compared++; if (!ok || cyc != 1 || send_device !== 2'd0 || send_port !== 32'h4) begin mismatched++; $display("FAIL mid_regrant0 got d=%0d p=%h want d=0 p=4", send_device, send_port); end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    compared++; if (send_done !== 4'b0001 || sent_count !== 32'd1) begin mismatched++; $display("FAIL mid_done0 got done=%b cnt=%0d want 0001/1", send_done, sent_count); end
    wait_valid(10, ok, cyc);
    compared++; if (!ok || send_device !== 2'd1 || send_port !== 32'h8000_0000) begin mismatched++; $display("FAIL mid_regrant1 got d=%0d p=%h want d=1 p=80000000", send_device, send_port); end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    set_all(0, 0, 0, 0);
    compared++; if (sent_count !== 32'd2) begin mismatched++; $display("FAIL mid_count2 got %0d want 2", sent_count); end
    $display("test_reset_mid_send done");
  endtask

  task automatic test_count_wrap;
    bit ok; int cyc;
    repeat (4) @(negedge clk);
    force dut.sent_count_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.sent_count_q;
    set_all(0, 0, 32'h1, 0);
    wait_valid(10, ok, cyc);
    compared++; if (!ok || send_device !== 2'd2) begin mismatched++; $display("FAIL wrap_grant got d=%0d want 2", send_device); end
    send_ack = 1'b1;
    @(negedge clk);
    send_ack = 1'b0;
    set_all(0, 0, 0, 0);
    compared++; if (sent_count !== 32'd0) begin mismatched++; $display("FAIL wrap_count got %h want 0", sent_count); end
    compared++; if (send_done !== 4'b0100) begin mismatched++; $display("FAIL wrap_done got %b want 0100", send_done); end
    $display("test_count_wrap done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ack_stall();
    test_reset_mid_send();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
